// File: rtl/fifo_wr_arbiter_if.sv
// Requester-side valid/ready lanes and FIFO write port shared by the write arbiter.
// master drives the requester lanes and FIFO status; slave is the arbiter.
interface fifo_wr_arbiter_if #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned DW   = 8
);
  localparam int unsigned IW = $clog2(NREQ);

  logic [NREQ-1:0]    req_valid;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_last;
  logic [NREQ-1:0]    req_ready;
  logic               fifo_full;
  logic               fifo_wr_en;
  logic [DW-1:0]      fifo_wr_data;
  logic [IW-1:0]      grant_id;
  logic               busy;

  modport master (
    output req_valid, req_data, req_last, fifo_full,
    input  req_ready, fifo_wr_en, fifo_wr_data, grant_id, busy
  );

  modport slave (
    input  req_valid, req_data, req_last, fifo_full,
    output req_ready, fifo_wr_en, fifo_wr_data, grant_id, busy
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port among NREQ valid/ready producers.
// Handshake and write data are combinational from the registered owner/state.
module fifo_wr_arbiter #(
  parameter int unsigned NREQ      = 4,
  parameter int unsigned DW        = 8,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  fifo_wr_arbiter_if.slave bus
);
  localparam int unsigned IW = $clog2(NREQ);
  localparam int unsigned CW = 4;
  localparam logic [CW-1:0] LAST_BEAT = CW'(MAX_BURST - 1);
  localparam logic [IW-1:0] RR_RESET  = IW'(NREQ - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] owner_q, owner_d;
  logic [IW-1:0] rr_ptr_q, rr_ptr_d;
  logic [CW-1:0] beat_cnt_q, beat_cnt_d;

  logic [IW-1:0] pick;
  logic [IW-1:0] cand;
  logic          any_req;
  logic          accept;
  logic          owner_valid;
  logic          owner_last;
  logic          xfer;
  logic [DW-1:0] lane [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_lane
    assign lane[g] = bus.req_data[g*DW +: DW];
  end

  // First valid requester after the last owner, wrapping modulo NREQ.
  always_comb begin
    pick    = '0;
    cand    = '0;
    any_req = 1'b0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand = IW'((32'(rr_ptr_q) + k) % NREQ);
      if (!any_req && bus.req_valid[cand]) begin
        any_req = 1'b1;
        pick    = cand;
      end
    end
  end

  assign owner_valid = bus.req_valid[owner_q];
  assign owner_last  = bus.req_last[owner_q];
  assign accept      = ena && (state_q == GRANT) && !bus.fifo_full;
  assign xfer        = accept && owner_valid;

  assign bus.req_ready    = accept ? (NREQ'(1) << owner_q) : '0;
  assign bus.fifo_wr_en   = xfer;
  assign bus.fifo_wr_data = xfer ? lane[owner_q] : '0;
  assign bus.grant_id     = owner_q;
  assign bus.busy         = (state_q == GRANT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      owner_q    <= '0;
      rr_ptr_q   <= RR_RESET;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  // Full or disabled cycles fall through with everything held, keeping the lock.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (ena && any_req) begin
          owner_d    = pick;
          beat_cnt_d = '0;
          state_d    = GRANT;
        end
      end
      GRANT: begin
        if (accept) begin
          if (owner_valid) begin
            beat_cnt_d = beat_cnt_q + CW'(1);
            if (owner_last || (beat_cnt_q == LAST_BEAT)) begin
              state_d  = IDLE;
              rr_ptr_d = owner_q;
            end
          end else begin
            // Owner dropped valid mid-burst: release without writing.
            state_d  = IDLE;
            rr_ptr_d = owner_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomised and directed bench for fifo_wr_arbiter with a scoreboard of expected FIFO writes.
module tb_fifo_wr_arbiter;
  localparam int unsigned NREQ      = 4;
  localparam int unsigned DW        = 8;
  localparam int unsigned MAX_BURST = 4;
  localparam int unsigned IW        = 2;
  localparam int          DEPTH     = 4096;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic ena   = 1'b0;

  fifo_wr_arbiter_if #(.NREQ(NREQ), .DW(DW)) bus ();

  fifo_wr_arbiter #(.NREQ(NREQ), .DW(DW), .MAX_BURST(MAX_BURST)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .ena  (ena),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [IW-1:0] id;
    logic [DW-1:0] data;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  // Producer beat stores, one per requester
  logic [DW-1:0] pdata [NREQ][DEPTH];
  bit            plast [NREQ][DEPTH];
  int            head  [NREQ];
  int            tail  [NREQ];
  bit            gate  [NREQ];

  // Reference model: who holds the write port, beats so far, last owner served
  bit m_busy;
  int m_owner;
  int m_rr;
  int m_beats;

  logic [NREQ-1:0] cur_valid, cur_last, act_hs, exp_ready;
  bit              cur_ena, cur_full;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_beat(input int r, input logic [DW-1:0] d, input bit l);
    if (tail[r] < DEPTH) begin
      pdata[r][tail[r]] = d;
      plast[r][tail[r]] = l;
      tail[r]++;
    end
  endtask

  task automatic drive();
    logic [NREQ*DW-1:0] dd;
    dd = '0;
    for (int i = 0; i < NREQ; i++) begin
      cur_valid[i] = (head[i] < tail[i]) && gate[i];
      cur_last[i]  = (head[i] < tail[i]) ? plast[i][head[i]] : 1'b0;
      dd[i*DW +: DW] = (head[i] < tail[i]) ? pdata[i][head[i]] : '0;
    end
    bus.req_valid = cur_valid;
    bus.req_last  = cur_last;
    bus.req_data  = dd;
  endtask

  task automatic model_update();
    int cand;
    if (!m_busy) begin
      if (cur_ena && (cur_valid != '0)) begin
        for (int k = 1; k <= NREQ; k++) begin
          cand = (m_rr + k) % NREQ;
          if (cur_valid[cand]) begin
            m_owner = cand;
            break;
          end
        end
        m_beats = 0;
        m_busy  = 1'b1;
      end
    end else if (cur_ena && !cur_full) begin
      if (cur_valid[m_owner]) begin
        m_beats++;
        if (cur_last[m_owner] || m_beats == MAX_BURST) begin
          m_busy = 1'b0;
          m_rr   = m_owner;
        end
      end else begin
        m_busy = 1'b0;
        m_rr   = m_owner;
      end
    end
  endtask

  // One clock: drive at negedge, check and predict, then advance model at posedge.
  task automatic step(input bit e, input bit f);
    @(negedge clk);
    ena           = e;
    cur_ena       = e;
    cur_full      = f;
    bus.fifo_full = f;
    drive();
    #1;
    exp_ready = (cur_ena && m_busy && !cur_full) ? (NREQ'(1) << m_owner) : '0;
    check("req_ready", 32'(bus.req_ready), 32'(exp_ready));
    check("busy", 32'(bus.busy), 32'(m_busy));
    check("grant_id", 32'(bus.grant_id), 32'(m_owner));
    if (exp_ready != '0 && cur_valid[m_owner])
      sb.push_back(exp_t'({IW'(m_owner), pdata[m_owner][head[m_owner]]}));
    act_hs = bus.req_valid & bus.req_ready;
    @(posedge clk);
    model_update();
    for (int i = 0; i < NREQ; i++)
      if (act_hs[i]) head[i]++;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, 32'(bus.req_ready), 32'h0);
    check({tag, "_wr_en"}, 32'(bus.fifo_wr_en), 32'h0);
    check({tag, "_wr_data"}, 32'(bus.fifo_wr_data), 32'h0);
    check({tag, "_grant_id"}, 32'(bus.grant_id), 32'h0);
    check({tag, "_busy"}, 32'(bus.busy), 32'h0);
  endtask

  task automatic mid_reset();
    @(negedge clk);
    ena = 1'b1;
    bus.fifo_full = 1'b0;
    drive();
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    m_busy  = 1'b0;
    m_owner = 0;
    m_rr    = NREQ - 1;
    m_beats = 0;
    @(negedge clk);
    ena   = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic run(input int n);
    for (int c = 0; c < n; c++) step(1'b1, 1'b0);
  endtask

  // Monitor: every FIFO write must match the oldest predicted write.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (bus.fifo_wr_en === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got data 0x%0h id %0d expected no write at %0t",
                   bus.fifo_wr_data, bus.grant_id, $time);
        end else begin
          e = sb.pop_front();
          check("wr_data", 32'(bus.fifo_wr_data), 32'(e.data));
          check("wr_owner", 32'(bus.grant_id), 32'(e.id));
        end
      end else begin
        check("wr_data_idle", 32'(bus.fifo_wr_data), 32'h0);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          checks++;
          errors++;
          $display("FAIL missing_write: got no write expected 0x%0h from %0d at %0t",
                   e.data, e.id, $time);
        end
      end
    end
  end

  initial begin
    int  guard;
    bit  pending;
    int  nb;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.req_last  = '0;
    bus.fifo_full = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      head[i] = 0;
      tail[i] = 0;
      gate[i] = 1'b1;
    end
    m_busy  = 1'b0;
    m_owner = 0;
    m_rr    = NREQ - 1;
    m_beats = 0;

    #12;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Single requester, three-beat burst
    push_beat(0, 8'h11, 1'b0);
    push_beat(0, 8'h22, 1'b0);
    push_beat(0, 8'h33, 1'b1);
    run(6);

    // All four requesters, single-beat bursts, round-robin order
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < NREQ; i++) push_beat(i, DW'(8'h40 + 16 * i + k), 1'b1);
    run(20);

    // Burst cap with a long stream that never asserts last
    for (int k = 0; k < 10; k++) push_beat(2, DW'(8'hA0 + k), 1'b0);
    run(16);

    // FIFO full stall in the middle of a four-beat burst
    for (int k = 0; k < 4; k++) push_beat(1, DW'(8'hB0 + k), k == 3);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    run(5);

    // Abandoned burst: requester 1 runs dry without last, requester 2 waiting
    push_beat(0, 8'hE0, 1'b1);
    run(3);
    push_beat(1, 8'hC0, 1'b0);
    push_beat(2, 8'hD0, 1'b1);
    run(8);

    // Enable low freezes a burst in progress
    for (int k = 0; k < 4; k++) push_beat(3, DW'(8'h70 + k), k == 3);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    run(5);

    // Reset during the second beat, then 0 beats 3 on re-arbitration
    for (int k = 0; k < 4; k++) push_beat(0, DW'(8'hF0 + k), k == 3);
    push_beat(3, 8'h9C, 1'b1);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    mid_reset();
    run(10);

    // Randomised traffic
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        gate[i] = ($urandom_range(0, 9) != 0);
        if (head[i] == tail[i] && $urandom_range(0, 7) == 0 && tail[i] + 8 < DEPTH) begin
          nb = $urandom_range(1, 6);
          for (int k = 0; k < nb; k++)
            push_beat(i, DW'($urandom), ($urandom_range(0, 2) == 0));
        end
      end
      step(($urandom_range(0, 9) != 0), ($urandom_range(0, 4) == 0));
    end

    // Drain everything with a bounded budget
    for (int i = 0; i < NREQ; i++) gate[i] = 1'b1;
    guard = 0;
    do begin
      step(1'b1, 1'b0);
      guard++;
      pending = m_busy;
      for (int i = 0; i < NREQ; i++) if (head[i] != tail[i]) pending = 1'b1;
    end while (pending && guard < 500);
    checks++;
    if (pending) begin
      errors++;
      $display("FAIL drain_timeout: got beats still pending after %0d cycles expected none", guard);
    end
    step(1'b1, 1'b0);
    #5;
    check("scoreboard_empty", 32'(sb.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write-port arbiter placed in front of the shared FIFO inside `tt_um_monishvr_fifo`. It lets up to NREQ producers share the FIFO's single write port. Grants are given in bursts, each capped at MAX_BURST beats. Beats are not forwarded while the FIFO reports full. Requester-side handshake is valid/ready; the FIFO side is a plain write-enable plus data.

## Interface
- NREQ, 4: number of requesters (2..8).
- DW, 8: data width in bits.
- MAX_BURST, 4: maximum beats per grant (1..16).
- IW, $clog2(NREQ): derived grant-index width; not overridden.

- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ena  in  1  design enable; low freezes arbitration and deasserts all ready.
- req_valid  in  NREQ  bit i: requester i has a beat on its data lane.
- req_data  in  NREQ*DW  lane i is bits [i*DW +: DW].
- req_last  in  NREQ  bit i: current beat of requester i ends its burst.
- req_ready  out  NREQ  bit i: beat of requester i is accepted this cycle.
- fifo_full  in  1  FIFO cannot accept a write this cycle.
- fifo_wr_en  out  1  write strobe to FIFO.
- fifo_wr_data  out  DW  write data to FIFO.
- grant_id  out  IW  current/last owner index.
- busy  out  1  high while in GRANT state.

## Operation
- Registered state: `state` (IDLE/GRANT), `owner` (IW), `rr_ptr` (IW), `beat_cnt` (4 bits).
- A transfer occurs for requester i when req_valid[i] and req_ready[i] are both high in the same cycle.
- req_ready[i] = ena & (state==GRANT) & (owner==i) & !fifo_full. This is combinational, and at most one bit is high.
- fifo_wr_en = |(req_valid & req_ready).
- fifo_wr_data = the owner's lane when fifo_wr_en is high, else 0.
- grant_id = owner. busy = (state==GRANT).

IDLE:
- If ena=1 and any req_valid bit is set:
  - owner <= first set bit searching rr_ptr+1, rr_ptr+2, … modulo NREQ.
  - beat_cnt <= 0.
  - state <= GRANT.
- Otherwise hold.

GRANT:
- On a transfer, beat_cnt <= beat_cnt+1.
- On a transfer with req_last[owner]=1 or beat_cnt==MAX_BURST-1:
  - state <= IDLE.
  - rr_ptr <= owner.
- If ena=1, fifo_full=0 and req_valid[owner]=0 (abandoned burst):
  - state <= IDLE.
  - rr_ptr <= owner.
  - No write occurs.
- fifo_full=1: no transfer and no abandon check. Hold state, owner and beat_cnt; the lock is kept.
- ena=0: hold everything. req_ready is 0, so no transfer.

Boundary and policy rules:
- Valid bits of non-owners are ignored during GRANT. Their data must be held stable by the producer until accepted.
- The owner is released after MAX_BURST beats even if req_last was never asserted. The owner then competes again with the lowest priority.
- rr_ptr wrap: after owner NREQ-1, the search starts at 0.
- req_last on a beat that is not accepted (fifo_full) has no effect.

Reset values:
- state=IDLE, owner=0, rr_ptr=NREQ-1 (requester 0 has first priority), beat_cnt=0.
- Outputs: req_ready=0, fifo_wr_en=0, fifo_wr_data=0, grant_id=0, busy=0.
- Reset asserted mid-burst aborts the burst immediately. Outputs reach their reset values asynchronously. A beat presented in that cycle is not written.

## Timing
- Arbitration latency: 1 cycle. A request seen in IDLE at edge n is granted, and its first beat can transfer, in cycle n+1.
- Throughput during a grant is 1 beat/cycle with FIFO not full.
- A burst of k beats occupies k+1 cycles including the arbitration cycle. There is no idle cycle inside a burst.
- Data path is zero-latency combinational: fifo_wr_en/fifo_wr_data appear in the same cycle as the handshake.
- fifo_full must be valid for the FIFO state in the current cycle.
- Back-to-back grants always return to IDLE for exactly one cycle between owners.
- A single requester with an unbounded stream gets MAX_BURST beats then 1 gap cycle, repeating.

## Test plan
- Reset then single requester: req_valid=4'b0001, data 0x11,0x22,0x33, last on 0x33. Expect grant_id=0 and busy=1 one cycle after request. Expect fifo_wr_en on 3 consecutive cycles with 0x11,0x22,0x33, then busy=0.
- Round-robin: all four requesters valid continuously with 1-beat bursts (last=1). Expect write order from lanes 0,1,2,3,0,1, with one IDLE cycle between each.
- Burst cap: requester 2 streams 0xA0..0xA9 with last=0 and MAX_BURST=4. Expect 0xA0..0xA3 written, busy drops one cycle, then 0xA4..0xA7 follow.
- Full stall: fifo_full=1 during beats 2–3 of a 4-beat burst. Expect req_ready=0 and fifo_wr_en=0 during the stall, the owner retained, and all 4 beats written in order after full drops.
- Abandon: owner 1 drops valid after 1 of 3 beats with no last. Expect return to IDLE the next edge, and requester 2 (also valid) granted next.
- Reset mid-burst: assert rst_n=0 during beat 2. Expect all outputs 0 immediately. After release, requester 0 wins first over simultaneous requests from 0 and 3.
